// File: rtl/data_bus_bridge.sv
// Bridge between a stalling core data port and a request/acknowledge memory bus.
// One transfer at a time: IDLE captures the request, WAIT drives the bus, RESP returns data.
module data_bus_bridge #(
    parameter int unsigned TIMEOUT  = 255,
    parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic [31:0] iAddress,
    input  logic [31:0] iWriteData,
    input  logic        iWriteEnable,
    input  logic        iReadEnable,
    input  logic [3:0]  iByteEnable,
    output logic [31:0] oReadData,
    output logic        oStall,
    output logic        oBusError,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic [3:0]  oMemBE,
    output logic        oMemWe,
    output logic        oMemReq,
    input  logic        iMemAck,
    input  logic [31:0] iMemRData
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value whose increment would reach TIMEOUT: the last WAIT cycle allowed.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t      state, next_state;
    logic [7:0]  cnt, cnt_next;
    logic [31:0] addr_r, wdata_r, rdata_r;
    logic [3:0]  be_r;
    logic        we_r, err_r;
    logic        capture, timeout_hit, stall;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        next_state  = state;
        cnt_next    = cnt;
        capture     = 1'b0;
        timeout_hit = 1'b0;
        stall       = 1'b0;
        case (state)
            IDLE: begin
                if (iWriteEnable || iReadEnable) begin
                    capture    = 1'b1;
                    stall      = 1'b1;
                    next_state = (iWriteEnable && iByteEnable == 4'b0000) ? RESP : WAIT;
                end
            end
            WAIT: begin
                stall = 1'b1;
                if (iMemAck) begin
                    cnt_next   = 8'd0;
                    next_state = RESP;
                end else if (cnt == TIMEOUT_LAST) begin
                    cnt_next    = 8'd0;
                    timeout_hit = 1'b1;
                    next_state  = RESP;
                end else begin
                    cnt_next = cnt + 8'd1;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    // NOTE: the bus-side capture registers are reset too, so the memory port reads all-zero out of reset.
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            be_r    <= 4'd0;
            we_r    <= 1'b0;
            rdata_r <= 32'd0;
            err_r   <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            err_r <= timeout_hit;
            if (capture) begin
                addr_r  <= iAddress;
                wdata_r <= iWriteData;
                we_r    <= iWriteEnable;
                be_r    <= iWriteEnable ? iByteEnable : 4'b1111;
            end
            if (state == WAIT && iMemAck && !we_r) begin
                rdata_r <= iMemRData;
            end else if (timeout_hit) begin
                rdata_r <= ERR_DATA;
            end
        end
    end

    // Stall is gated by reset because the core may hold a request while the bridge is in reset.
    assign oStall    = stall && iRST_N;
    assign oMemReq   = (state == WAIT);
    assign oMemWe    = we_r && (state == WAIT);
    assign oMemAddr  = addr_r;
    assign oMemWData = wdata_r;
    assign oMemBE    = be_r;
    assign oReadData = rdata_r;
    assign oBusError = err_r;

endmodule
